// File: rtl/shift_step_scheduler_if.sv
// Switch inputs and step/position outputs of shift_step_scheduler, grouped as one bundle.
// master = board top / testbench side, slave = the scheduler.
interface shift_step_scheduler_if;
  logic       run_i;
  logic       dir_i;
  logic       led_step_o;
  logic       hex_step_o;
  logic [3:0] led_pos_o;
  logic [2:0] hex_pos_o;
  logic       led_act_o;
  logic       hex_act_o;
  logic       dir_o;
  logic       wrap_o;

  modport master (
    output run_i, dir_i,
    input  led_step_o, hex_step_o, led_pos_o, hex_pos_o, led_act_o, hex_act_o, dir_o, wrap_o
  );

  modport slave (
    input  run_i, dir_i,
    output led_step_o, hex_step_o, led_pos_o, hex_pos_o, led_act_o, hex_act_o, dir_o, wrap_o
  );
endinterface

// File: rtl/shift_step_scheduler.sv
// Step sequencer for the LED bar / HEX digit shifters: one prescaled tick shared LED then HEX.
// Optional macro SCHED_DEBOUNCE_EN adds a counter filter behind each input synchronizer.
module shift_step_scheduler #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned STEP_HZ         = 4,
  parameter int unsigned LED_POSITIONS   = 10,
  parameter int unsigned HEX_POSITIONS   = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  shift_step_scheduler_if.slave  bus
);

  localparam int unsigned DIV = CLK_HZ / STEP_HZ;
  localparam int unsigned CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [3:0]    LED_LAST = 4'(LED_POSITIONS - 1);
  localparam logic [2:0]    HEX_LAST = 3'(HEX_POSITIONS - 1);

  if (DIV < 2) begin : g_div_chk
    $error("shift_step_scheduler: CLK_HZ/STEP_HZ must be >= 2");
  end
  if (LED_POSITIONS < 2 || LED_POSITIONS > 16) begin : g_led_chk
    $error("shift_step_scheduler: LED_POSITIONS must be 2..16");
  end
  if (HEX_POSITIONS < 2 || HEX_POSITIONS > 8) begin : g_hex_chk
    $error("shift_step_scheduler: HEX_POSITIONS must be 2..8");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_db_chk
    $error("shift_step_scheduler: DEBOUNCE_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {StIdle, StLedRun, StHexRun, StPause} state_e;

  state_e        r_state, w_state_nxt;
  logic          r_phase_hex;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_run_s1, r_run_s2, r_dir_s1, r_dir_s2;
  logic          w_run_s, w_dir_s;
  logic          w_run_state, w_tick, w_at_end;
  logic [3:0]    r_led_pos;
  logic [2:0]    r_hex_pos;
  logic          r_led_step, r_hex_step, r_wrap;
  logic          w_led_act, w_hex_act;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_run_s1 <= 1'b0;
      r_run_s2 <= 1'b0;
      r_dir_s1 <= 1'b0;
      r_dir_s2 <= 1'b0;
    end else begin
      r_run_s1 <= bus.run_i;
      r_run_s2 <= r_run_s1;
      r_dir_s1 <= bus.dir_i;
      r_dir_s2 <= r_dir_s1;
    end
  end

`ifdef SCHED_DEBOUNCE_EN
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic           r_run_f, r_dir_f;
  logic [DBW-1:0] r_run_cnt, r_dir_cnt;

  // A level is accepted only after DEBOUNCE_CYCLES consecutive cycles away from the filtered value.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_run_f   <= 1'b0;
      r_run_cnt <= '0;
      r_dir_f   <= 1'b0;
      r_dir_cnt <= '0;
    end else begin
      if (r_run_s2 == r_run_f) begin
        r_run_cnt <= '0;
      end else if (r_run_cnt == DB_LAST) begin
        r_run_f   <= r_run_s2;
        r_run_cnt <= '0;
      end else begin
        r_run_cnt <= r_run_cnt + DBW'(1);
      end
      if (r_dir_s2 == r_dir_f) begin
        r_dir_cnt <= '0;
      end else if (r_dir_cnt == DB_LAST) begin
        r_dir_f   <= r_dir_s2;
        r_dir_cnt <= '0;
      end else begin
        r_dir_cnt <= r_dir_cnt + DBW'(1);
      end
    end
  end

  assign w_run_s = r_run_f;
  assign w_dir_s = r_dir_f;
`else
  assign w_run_s = r_run_s2;
  assign w_dir_s = r_dir_s2;
`endif

  // Prescaler and tick; a run drop suppresses the tick in the same cycle.
  always_comb begin
    w_run_state = (r_state == StLedRun) || (r_state == StHexRun);
    w_tick      = w_run_state && w_run_s && (r_cnt == CNT_LAST);
    w_cnt_nxt   = '0;
    if (w_run_state && w_run_s && (r_cnt != CNT_LAST)) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
    if (r_state == StHexRun) begin
      w_at_end = (r_hex_pos == (w_dir_s ? 3'd0 : HEX_LAST));
    end else begin
      w_at_end = (r_led_pos == (w_dir_s ? 4'd0 : LED_LAST));
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:   if (w_run_s) w_state_nxt = StLedRun;
      StLedRun: begin
        if (!w_run_s)              w_state_nxt = StPause;
        else if (w_tick && w_at_end) w_state_nxt = StHexRun;
      end
      StHexRun: begin
        if (!w_run_s)              w_state_nxt = StPause;
        else if (w_tick && w_at_end) w_state_nxt = StLedRun;
      end
      StPause:  if (w_run_s) w_state_nxt = r_phase_hex ? StHexRun : StLedRun;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_led_act = 1'b0;
    w_hex_act = 1'b0;
    unique case (r_state)
      StLedRun: w_led_act = 1'b1;
      StHexRun: w_hex_act = 1'b1;
      StPause: begin
        w_led_act = !r_phase_hex;
        w_hex_act = r_phase_hex;
      end
      default: ;
    endcase
  end

  // Positions and strobes are registered together so a strobe coincides with its new position.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cnt       <= '0;
      r_phase_hex <= 1'b0;
      r_led_pos   <= '0;
      r_hex_pos   <= '0;
      r_led_step  <= 1'b0;
      r_hex_step  <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_led_step <= 1'b0;
      r_hex_step <= 1'b0;
      r_wrap     <= 1'b0;
      if (w_state_nxt == StLedRun)      r_phase_hex <= 1'b0;
      else if (w_state_nxt == StHexRun) r_phase_hex <= 1'b1;

      if (r_state == StIdle && w_run_s) begin
        r_led_pos <= w_dir_s ? LED_LAST : 4'd0;
      end else if (w_tick && r_state == StLedRun) begin
        if (!w_at_end) begin
          r_led_pos  <= w_dir_s ? r_led_pos - 4'd1 : r_led_pos + 4'd1;
          r_led_step <= 1'b1;
        end else begin
          r_hex_pos  <= w_dir_s ? HEX_LAST : 3'd0;
          r_hex_step <= 1'b1;
        end
      end else if (w_tick && r_state == StHexRun) begin
        if (!w_at_end) begin
          r_hex_pos  <= w_dir_s ? r_hex_pos - 3'd1 : r_hex_pos + 3'd1;
          r_hex_step <= 1'b1;
        end else begin
          r_led_pos  <= w_dir_s ? LED_LAST : 4'd0;
          r_led_step <= 1'b1;
          r_wrap     <= 1'b1;
        end
      end
    end
  end

  assign bus.led_step_o = r_led_step;
  assign bus.hex_step_o = r_hex_step;
  assign bus.led_pos_o  = r_led_pos;
  assign bus.hex_pos_o  = r_hex_pos;
  assign bus.led_act_o  = w_led_act;
  assign bus.hex_act_o  = w_hex_act;
  assign bus.dir_o      = w_dir_s;
  assign bus.wrap_o     = r_wrap;

endmodule

// File: tb/tb_shift_step_scheduler.sv
// Bench for shift_step_scheduler: directed scenarios plus random run/dir activity,
// every cycle compared against a tick-count reference model.
module tb_shift_step_scheduler;
  localparam int unsigned CLK_HZ = 8;
  localparam int unsigned STEP_HZ = 2;
  localparam int DIV = 4;
  localparam int LED_N = 10;
  localparam int HEX_N = 6;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  shift_step_scheduler_if bus ();

  shift_step_scheduler #(
    .CLK_HZ          (CLK_HZ),
    .STEP_HZ         (STEP_HZ),
    .LED_POSITIONS   (LED_N),
    .HEX_POSITIONS   (HEX_N),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model: mode 0 idle, 1 running, 2 paused; m_left = cycles until the next tick.
  int m_mode, m_left, m_lpos, m_hpos, m_rlen, m_dlen;
  bit m_hex, m_lstep, m_hstep, m_wrap;
  bit m_rs1, m_rs2, m_ds1, m_ds2, m_rf, m_df;

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_lpos = 0; m_hpos = 0; m_rlen = 0; m_dlen = 0;
    m_hex = 0; m_lstep = 0; m_hstep = 0; m_wrap = 0;
    m_rs1 = 0; m_rs2 = 0; m_ds1 = 0; m_ds2 = 0; m_rf = 0; m_df = 0;
  endtask

  function automatic bit run_s();
`ifdef SCHED_DEBOUNCE_EN
    return m_rf;
`else
    return m_rs2;
`endif
  endfunction

  function automatic bit dir_s();
`ifdef SCHED_DEBOUNCE_EN
    return m_df;
`else
    return m_ds2;
`endif
  endfunction

  task automatic model_tick(input bit d);
    if (!m_hex) begin
      if (m_lpos != (d ? 0 : LED_N - 1)) begin
        m_lpos += d ? -1 : 1; m_lstep = 1;
      end else begin
        m_hex = 1; m_hpos = d ? HEX_N - 1 : 0; m_hstep = 1;
      end
    end else begin
      if (m_hpos != (d ? 0 : HEX_N - 1)) begin
        m_hpos += d ? -1 : 1; m_hstep = 1;
      end else begin
        m_hex = 0; m_lpos = d ? LED_N - 1 : 0; m_lstep = 1; m_wrap = 1;
      end
    end
  endtask

  task automatic model_edge(input bit run_in, input bit dir_in);
    bit rs, ds;
    rs = run_s();
    ds = dir_s();
    m_lstep = 0; m_hstep = 0; m_wrap = 0;
    case (m_mode)
      0: if (rs) begin m_mode = 1; m_hex = 0; m_lpos = ds ? LED_N - 1 : 0; m_left = DIV; end
      1: if (!rs) m_mode = 2;
         else begin
           m_left--;
           if (m_left == 0) begin m_left = DIV; model_tick(ds); end
         end
      default: if (rs) begin m_mode = 1; m_left = DIV; end
    endcase
    if (m_rs2 != m_rf) begin m_rlen++; if (m_rlen == DB) begin m_rf = m_rs2; m_rlen = 0; end end
    else m_rlen = 0;
    if (m_ds2 != m_df) begin m_dlen++; if (m_dlen == DB) begin m_df = m_ds2; m_dlen = 0; end end
    else m_dlen = 0;
    m_rs2 = m_rs1; m_rs1 = run_in;
    m_ds2 = m_ds1; m_ds1 = dir_in;
  endtask

  function automatic logic [12:0] exp_vec();
    return {m_lstep, m_hstep, 4'(m_lpos), 3'(m_hpos),
            (m_mode != 0) && !m_hex, (m_mode != 0) && m_hex, dir_s(), m_wrap};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {bus.led_step_o, bus.hex_step_o, bus.led_pos_o, bus.hex_pos_o,
            bus.led_act_o, bus.hex_act_o, bus.dir_o, bus.wrap_o};
  endfunction

  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge(bus.run_i, bus.dir_i);
    #1;
    chk("cycle", dut_vec(), exp_vec());
  endtask

  // Leaves the bench #1 after a rising edge with reset released and inputs at run/dir.
  task automatic do_reset(input bit run, input bit dir);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    bus.run_i = 1'b0;
    bus.dir_i = 1'b0;
    #1;
    chk("reset_outs", dut_vec(), 13'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.run_i = run;
    bus.dir_i = dir;
  endtask

  initial begin
    int got;
    bit found;
    model_reset();
    bus.run_i = 1'b0;
    bus.dir_i = 1'b0;

    // 1: idle after reset with run low.
    do_reset(1'b0, 1'b0);
    repeat (100) cyc();
    chk("idle_100", dut_vec(), 13'd0);

    // 2: run, left direction; full LED+HEX period.
    do_reset(1'b1, 1'b0);
    for (int k = 0; k < 70; k++) begin
      cyc();
`ifndef SCHED_DEBOUNCE_EN
      if (k == 1) chk("act_c1", 13'(bus.led_act_o), 13'd0);
      if (k == 2) chk("act_c2", 13'(bus.led_act_o), 13'd1);
      if (k == 5) chk("step_c5", 13'(bus.led_step_o), 13'd0);
      if (k == 6) chk("step_c6", {bus.led_step_o, bus.led_pos_o}, {1'b1, 4'd1});
      if (k == 42) chk("hex_sw", {bus.hex_step_o, bus.hex_pos_o, bus.hex_act_o}, {1'b1, 3'd0, 1'b1});
      if (k == 66) chk("wrap", {bus.led_step_o, bus.wrap_o, bus.led_pos_o}, {2'b11, 4'd0});
`endif
    end

    // 3: run, right direction.
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 70; k++) begin
      cyc();
`ifndef SCHED_DEBOUNCE_EN
      if (k == 2) chk("r_entry", 13'(bus.led_pos_o), 13'd9);
      if (k == 6) chk("r_first", 13'(bus.led_pos_o), 13'd8);
      if (k == 38) chk("r_led0", 13'(bus.led_pos_o), 13'd0);
      if (k == 42) chk("r_hex5", {bus.hex_step_o, bus.hex_pos_o}, {1'b1, 3'd5});
      if (k == 62) chk("r_hex0", 13'(bus.hex_pos_o), 13'd0);
`endif
    end

    // 4: pause exactly on the tick cycle, then resume.
    do_reset(1'b1, 1'b0);
    for (int k = 0; k < 24; k++) begin
      cyc();
`ifndef SCHED_DEBOUNCE_EN
      if (k == 3) bus.run_i = 1'b0;
      if (k == 6) chk("pause_nostep", {bus.led_step_o, bus.led_act_o, bus.led_pos_o}, {2'b01, 4'd0});
      if (k == 9) bus.run_i = 1'b1;
      if (k == 15) chk("resume_c15", 13'(bus.led_step_o), 13'd0);
      if (k == 16) chk("resume_c16", {bus.led_step_o, bus.led_pos_o}, {1'b1, 4'd1});
`endif
    end

    // 5: reverse direction at LED position 4.
    do_reset(1'b1, 1'b0);
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      cyc();
      if (bus.led_step_o && bus.led_pos_o == 4'd4) found = 1;
    end
    chk("rev_reach4", 13'(found), 13'd1);
    bus.dir_i = 1'b1;
    got = 0;
    for (int k = 0; k < 400 && got < 5; k++) begin
      cyc();
`ifndef SCHED_DEBOUNCE_EN
      if (bus.led_step_o) begin
        chk("rev_led_pos", 13'(bus.led_pos_o), 13'(3 - got));
        got++;
      end else if (bus.hex_step_o) begin
        chk("rev_hex_entry", {bus.hex_pos_o, 4'(got)}, {3'd5, 4'd4});
        got++;
      end
`else
      if (bus.led_step_o || bus.hex_step_o) got++;
`endif
    end
    chk("rev_steps", 13'(got), 13'd5);

    // 6: asynchronous reset in the middle of the HEX phase.
    do_reset(1'b1, 1'b0);
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      cyc();
      if (bus.hex_step_o && bus.hex_pos_o == 3'd2) found = 1;
    end
    chk("hex_reach2", 13'(found), 13'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset", dut_vec(), 13'd0);
    bus.run_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) cyc();

`ifdef SCHED_DEBOUNCE_EN
    // Short run glitch must be filtered out.
    do_reset(1'b0, 1'b0);
    repeat (10) cyc();
    bus.run_i = 1'b1;
    repeat (5) cyc();
    bus.run_i = 1'b0;
    repeat (40) cyc();
    chk("glitch", dut_vec(), 13'd0);
`endif

    // Random run/dir activity.
    do_reset(1'b0, 1'b0);
    for (int s = 0; s < 60; s++) begin
      bus.run_i = ($urandom_range(0, 3) != 0);
      bus.dir_i = $urandom_range(0, 1) == 1;
      repeat ($urandom_range(1, 40)) cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
